// File: rtl/vadd_pipe_kernel.sv
// ---------------------------------------------------------------------------
// vadd_pipe_kernel
//
// Pipelined, lane-parametrised vector-add kernel. Each C_DATA_WIDTH beat is
// split into C_LANE_WIDTH unsigned lanes; cfg_addend is added to every lane
// when the beat is accepted. The result then travels through C_STAGES
// register stages that apply full avail/ready backpressure and collapse
// bubbles. The kernel also keeps a count of output beats and a sticky flag
// that records any lane carry-out.
//
// Optional build macro:
//   VADD_SATURATE_EN - when defined, every lane saturates to all ones on a
//                      carry-out instead of wrapping modulo 2^C_LANE_WIDTH.
//
// Parameters:
//   C_DATA_WIDTH - beat width in bits (a multiple of C_LANE_WIDTH)
//   C_LANE_WIDTH - lane width in bits
//   C_STAGES     - number of register stages (1..4); equals the latency
//
// Ports:
//   clk        - kernel clock, rising edge
//   reset      - synchronous, active-low reset
//   in_ready   - kernel accepts in_data this cycle
//   in_avail   - in_data valid
//   in_data    - input beat, lane i at [i*C_LANE_WIDTH +: C_LANE_WIDTH]
//   out_ready  - downstream accepts out_data
//   out_avail  - out_data valid
//   out_data   - result beat
//   cfg_addend - addend for every lane, sampled with each accepted beat
//   cfg_clear  - one-cycle pulse clearing beat_count and ovf_sticky
//   beat_count - output handshakes since reset/clear (wraps)
//   ovf_sticky - set once any lane of an accepted beat carried out
// ---------------------------------------------------------------------------
module vadd_pipe_kernel #(
    parameter int C_DATA_WIDTH = 512,
    parameter int C_LANE_WIDTH = 32,
    parameter int C_STAGES     = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    output logic                    in_ready,
    input  logic                    in_avail,
    input  logic [C_DATA_WIDTH-1:0] in_data,
    input  logic                    out_ready,
    output logic                    out_avail,
    output logic [C_DATA_WIDTH-1:0] out_data,
    input  logic [C_LANE_WIDTH-1:0] cfg_addend,
    input  logic                    cfg_clear,
    output logic [31:0]             beat_count,
    output logic                    ovf_sticky
);

    localparam int N_LANES = C_DATA_WIDTH / C_LANE_WIDTH;
    localparam int LAST    = C_STAGES - 1;

    logic [C_STAGES-1:0]     stage_valid;
    logic [C_STAGES-1:0]     stage_load;
    logic [C_DATA_WIDTH-1:0] stage_data [C_STAGES];
    logic [C_DATA_WIDTH-1:0] lane_result;
    logic [N_LANES-1:0]      lane_carry;
    logic                    in_fire;
    logic                    out_fire;

    // Per-lane adder. The extra top bit of the sum is the lane carry-out,
    // which feeds both the overflow flag and (optionally) saturation.
    for (genvar i = 0; i < N_LANES; i++) begin : g_lane
        logic [C_LANE_WIDTH:0] lane_sum;

        assign lane_sum      = {1'b0, in_data[i*C_LANE_WIDTH +: C_LANE_WIDTH]} + {1'b0, cfg_addend};
        assign lane_carry[i] = lane_sum[C_LANE_WIDTH];
`ifdef VADD_SATURATE_EN
        assign lane_result[i*C_LANE_WIDTH +: C_LANE_WIDTH] =
            lane_sum[C_LANE_WIDTH] ? {C_LANE_WIDTH{1'b1}} : lane_sum[C_LANE_WIDTH-1:0];
`else
        assign lane_result[i*C_LANE_WIDTH +: C_LANE_WIDTH] = lane_sum[C_LANE_WIDTH-1:0];
`endif
    end

    // Stage k may load when some stage at or after it is empty, or when the
    // last stage is draining. This is the unrolled form of the chain
    // ld[k] = !v[k] || ld[k+1]; writing it out avoids a self-referencing
    // vector in the combinational logic.
    always_comb begin
        logic chain_full;
        stage_load = '0;
        chain_full = 1'b1;
        for (int k = 0; k < C_STAGES; k++) begin
            chain_full = 1'b1;
            for (int j = k; j < C_STAGES; j++) begin
                chain_full = chain_full & stage_valid[j];
            end
            stage_load[k] = !chain_full || out_ready;
        end
    end

    assign in_ready  = stage_load[0];
    assign out_avail = stage_valid[LAST];
    assign out_data  = stage_data[LAST];
    assign in_fire   = in_avail && in_ready;
    assign out_fire  = out_avail && out_ready;

    // Valid bits: the only pipeline state that is reset, so a reset
    // discards every beat in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stage_valid <= '0;
        end else begin
            if (stage_load[0]) begin
                stage_valid[0] <= in_avail;
            end
            for (int k = 1; k < C_STAGES; k++) begin
                if (stage_load[k]) begin
                    stage_valid[k] <= stage_valid[k-1];
                end
            end
        end
    end

    // Data registers: the sum is captured in stage 0, later stages only
    // delay it. No reset needed since valid bits qualify the contents.
    always_ff @(posedge clk) begin
        if (stage_load[0]) begin
            stage_data[0] <= lane_result;
        end
        for (int k = 1; k < C_STAGES; k++) begin
            if (stage_load[k]) begin
                stage_data[k] <= stage_data[k-1];
            end
        end
    end

    // Status: clear has priority over a same-cycle handshake or overflow,
    // so that cycle's event is dropped rather than counted.
    always_ff @(posedge clk) begin
        if (!reset) begin
            beat_count <= '0;
            ovf_sticky <= 1'b0;
        end else if (cfg_clear) begin
            beat_count <= '0;
            ovf_sticky <= 1'b0;
        end else begin
            if (out_fire) begin
                beat_count <= beat_count + 32'd1;
            end
            if (in_fire && (|lane_carry)) begin
                ovf_sticky <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vadd_pipe_kernel.sv
// ---------------------------------------------------------------------------
// tb_vadd_pipe_kernel
//
// Self-checking bench for vadd_pipe_kernel (512-bit beats, 32-bit lanes,
// 2 stages). A reference model holds the beats in flight as a queue of
// expected results; a monitor compares the kernel against it every cycle,
// and directed scenarios add literal expectations.
// ---------------------------------------------------------------------------
module tb_vadd_pipe_kernel;

    localparam int DW = 512;
    localparam int LW = 32;
    localparam int ST = 2;
    localparam int NL = DW / LW;

    logic          clk;
    logic          reset;
    logic          in_ready;
    logic          in_avail;
    logic [DW-1:0] in_data;
    logic          out_ready;
    logic          out_avail;
    logic [DW-1:0] out_data;
    logic [LW-1:0] cfg_addend;
    logic          cfg_clear;
    logic [31:0]   beat_count;
    logic          ovf_sticky;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic [DW-1:0] data;
        int            acc;
    } beat_t;

    beat_t       model_q[$];
    logic [31:0] model_count;
    logic        model_ovf;
    bit          model_on = 0;

    vadd_pipe_kernel #(
        .C_DATA_WIDTH(DW),
        .C_LANE_WIDTH(LW),
        .C_STAGES    (ST)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_ready  (in_ready),
        .in_avail  (in_avail),
        .in_data   (in_data),
        .out_ready (out_ready),
        .out_avail (out_avail),
        .out_data  (out_data),
        .cfg_addend(cfg_addend),
        .cfg_clear (cfg_clear),
        .beat_count(beat_count),
        .ovf_sticky(ovf_sticky)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case a scenario wedges.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // One comparison: bump the counters and report a mismatch.
    task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                               input logic [DW-1:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Reference arithmetic: add the addend to every lane, note any carry.
    function automatic void model_beat(input logic [DW-1:0] din, input logic [LW-1:0] add,
                                       output logic [DW-1:0] dout, output logic carry);
        logic [LW:0] s;
        dout  = '0;
        carry = 1'b0;
        for (int i = 0; i < NL; i++) begin
            s = {1'b0, din[i*LW +: LW]} + {1'b0, add};
            if (s[LW]) carry = 1'b1;
`ifdef VADD_SATURATE_EN
            dout[i*LW +: LW] = s[LW] ? {LW{1'b1}} : s[LW-1:0];
`else
            dout[i*LW +: LW] = s[LW-1:0];
`endif
        end
    endfunction

    // Monitor: on every falling edge compare the kernel against the model,
    // then fold in the events that the coming rising edge will commit.
    always @(negedge clk) begin
        logic [DW-1:0] exp_data;
        logic          carry;
        logic          exp_avail;
        beat_t         b;
        if (model_on) begin
            exp_avail = (model_q.size() > 0) && (cyc >= model_q[0].acc + ST);
            checkOutput("out_avail", out_avail, exp_avail);
            if (out_avail && model_q.size() > 0) begin
                checkOutput("out_data", out_data, model_q[0].data);
            end
            checkOutput("in_ready", in_ready, !(model_q.size() == ST && !out_ready));
            checkOutput("beat_count", beat_count, model_count);
            checkOutput("ovf_sticky", ovf_sticky, model_ovf);
            if (!reset) begin
                model_q.delete();
                model_count = '0;
                model_ovf   = 1'b0;
            end else begin
                model_beat(in_data, cfg_addend, exp_data, carry);
                if (cfg_clear) begin
                    model_count = '0;
                    model_ovf   = 1'b0;
                end else begin
                    if (out_avail && out_ready) model_count = model_count + 32'd1;
                    if (in_avail && in_ready && carry) model_ovf = 1'b1;
                end
                if (out_avail && out_ready && model_q.size() > 0) begin
                    void'(model_q.pop_front());
                end
                if (in_avail && in_ready) begin
                    b.data = exp_data;
                    b.acc  = cyc;
                    model_q.push_back(b);
                end
            end
        end else if (!reset) begin
            model_on    = 1;
            model_q.delete();
            model_count = '0;
            model_ovf   = 1'b0;
        end
        cyc++;
    end

    // Pulse reset low for one rising edge; called at posedge+1.
    task automatic doReset();
        in_avail  = 1'b0;
        cfg_clear = 1'b0;
        reset     = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    // Present one beat and hold it until accepted; returns at posedge+1
    // after the accepting edge with in_avail still high.
    task automatic applyStimulus(input logic [DW-1:0] data, input logic [LW-1:0] add);
        bit hs;
        int budget;
        hs       = 0;
        budget   = 0;
        in_avail   = 1'b1;
        in_data    = data;
        cfg_addend = add;
        while (!hs && budget < 200) begin
            @(negedge clk);
            hs = in_ready;
            @(posedge clk);
            #1;
            budget++;
        end
        if (!hs) checkOutput("input_timeout", 0, 1);
    endtask

    function automatic logic [DW-1:0] random_beat();
        logic [DW-1:0] r;
        for (int i = 0; i < NL; i++) r[i*LW +: LW] = $urandom;
        return r;
    endfunction

    // Directed scenarios.
    initial begin
        logic [DW-1:0] d;
        logic [DW-1:0] e;
        int            start_cyc;
        int            sent;
        int            budget;
        bit            hs;

        reset      = 1'b0;
        in_avail   = 1'b0;
        in_data    = '0;
        out_ready  = 1'b0;
        cfg_addend = '0;
        cfg_clear  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;

        // Reset state and single beat: lanes 0..15 plus 1, latency 2.
        $display("[TB] single beat latency");
        doReset();
        @(negedge clk);
        checkOutput("rst_out_avail", out_avail, 0);
        checkOutput("rst_in_ready", in_ready, 1);
        checkOutput("rst_beat_count", beat_count, 0);
        checkOutput("rst_ovf", ovf_sticky, 0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int i = 0; i < NL; i++) begin
            d[i*LW +: LW] = i;
            e[i*LW +: LW] = i + 1;
        end
        applyStimulus(d, 32'd1);
        in_avail = 1'b0;
        @(negedge clk);
        checkOutput("lat_early", out_avail, 0);
        @(negedge clk);
        checkOutput("lat_avail", out_avail, 1);
        checkOutput("lat_data", out_data, e);
        @(negedge clk);
        checkOutput("lat_count", beat_count, 1);

        // 100 back-to-back beats, one per cycle.
        $display("[TB] back-to-back stream");
        @(posedge clk);
        #1;
        doReset();
        out_ready = 1'b1;
        start_cyc = cyc;
        for (int b = 0; b < 100; b++) begin
            for (int i = 0; i < NL; i++) d[i*LW +: LW] = b * NL + i;
            applyStimulus(d, 32'd3);
        end
        checkOutput("stream_cycles", cyc - start_cyc, 100);
        in_avail = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("stream_count", beat_count, 100);

        // Random in_avail/out_ready over 1000 beats.
        $display("[TB] random backpressure");
        @(posedge clk);
        #1;
        doReset();
        out_ready = 1'b0;
        sent      = 0;
        budget    = 0;
        hs        = 0;
        while (sent < 1000 && budget < 20000) begin
            if (hs) in_avail = 1'b0;
            out_ready = 1'($urandom_range(0, 1));
            if (!in_avail && $urandom_range(0, 1) == 1) begin
                in_avail = 1'b1;
                in_data  = random_beat();
                if ($urandom_range(0, 7) == 0) cfg_addend = $urandom;
            end
            @(negedge clk);
            hs = in_avail && in_ready;
            if (hs) sent++;
            @(posedge clk);
            #1;
            budget++;
        end
        checkOutput("rand_sent", sent, 1000);
        in_avail  = 1'b0;
        out_ready = 1'b1;
        repeat (8) @(negedge clk);
        checkOutput("rand_count", beat_count, 1000);

        // Lane at max plus one: wrap (or saturate) and raise overflow.
        $display("[TB] lane overflow");
        @(posedge clk);
        #1;
        doReset();
        out_ready = 1'b1;
        for (int i = 0; i < NL; i++) begin
            d[i*LW +: LW] = i;
            e[i*LW +: LW] = i + 1;
        end
        d[LW-1:0] = 32'hFFFF_FFFF;
`ifdef VADD_SATURATE_EN
        e[LW-1:0] = 32'hFFFF_FFFF;
`else
        e[LW-1:0] = 32'h0;
`endif
        applyStimulus(d, 32'd1);
        in_avail = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("ovf_data", out_data, e);
        checkOutput("ovf_flag", ovf_sticky, 1);

        // Clear coinciding with an output handshake at beat_count=5.
        $display("[TB] clear versus handshake");
        @(posedge clk);
        #1;
        doReset();
        out_ready = 1'b1;
        for (int b = 0; b < 5; b++) begin
            d = '0;
            d[LW-1:0] = (b == 0) ? 32'hFFFF_FFFF : b;
            applyStimulus(d, 32'd2);
        end
        in_avail = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("pre_clear_count", beat_count, 5);
        checkOutput("pre_clear_ovf", ovf_sticky, 1);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        applyStimulus(random_beat(), 32'd0);
        in_avail = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("clear_held", out_avail, 1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        cfg_clear = 1'b1;
        @(posedge clk);
        #1;
        cfg_clear = 1'b0;
        @(negedge clk);
        checkOutput("clear_count", beat_count, 0);
        checkOutput("clear_ovf", ovf_sticky, 0);

        // Fill the pipe, reset mid-stream, then confirm nothing stale leaks.
        $display("[TB] reset with full pipe");
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        applyStimulus(random_beat(), 32'd5);
        applyStimulus(random_beat(), 32'd6);
        in_avail = 1'b0;
        @(negedge clk);
        checkOutput("full_in_ready", in_ready, 0);
        checkOutput("full_out_avail", out_avail, 1);
        @(posedge clk);
        #1;
        reset    = 1'b0;
        in_avail = 1'b1;
        in_data  = random_beat();
        @(posedge clk);
        #1;
        reset    = 1'b1;
        in_avail = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_avail", out_avail, 0);
        checkOutput("post_rst_ready", in_ready, 1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        repeat (6) @(negedge clk);
        checkOutput("post_rst_count", beat_count, 0);

        @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
